// File: rtl/rpg_pkg.sv
// Reference pattern generator shared definitions.
// Modes, tap pairs, FSM states and the LFSR seed.
package rpg_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MARK = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam int LFSR_W = 31;
  localparam logic [LFSR_W-1:0] SEED = '1;

  localparam logic [4:0] N7  = 5'd7;
  localparam logic [4:0] T7  = 5'd6;
  localparam logic [4:0] N15 = 5'd15;
  localparam logic [4:0] T15 = 5'd14;
  localparam logic [4:0] N23 = 5'd23;
  localparam logic [4:0] T23 = 5'd18;
  localparam logic [4:0] N31 = 5'd31;
  localparam logic [4:0] T31 = 5'd28;

  function automatic logic [4:0] tap_n(mode_e m);
    logic [4:0] r;
    r = N7;
    unique case (m)
      MODE_PRBS7:  r = N7;
      MODE_PRBS15: r = N15;
      MODE_PRBS23: r = N23;
      MODE_PRBS31: r = N31;
      default:     r = N7;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] tap_t(mode_e m);
    logic [4:0] r;
    r = T7;
    unique case (m)
      MODE_PRBS7:  r = T7;
      MODE_PRBS15: r = T15;
      MODE_PRBS23: r = T23;
      MODE_PRBS31: r = T31;
      default:     r = T7;
    endcase
    return r;
  endfunction

  function automatic logic [LFSR_W-1:0] act_mask(mode_e m);
    logic [LFSR_W-1:0] r;
    r = 31'h0000007f;
    unique case (m)
      MODE_PRBS7:  r = 31'h0000007f;
      MODE_PRBS15: r = 31'h00007fff;
      MODE_PRBS23: r = 31'h007fffff;
      MODE_PRBS31: r = 31'h7fffffff;
      default:     r = 31'h0000007f;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rpg_lfsr.sv
// 31-bit Fibonacci LFSR with mode-selected taps.
// Inactive upper bits are forced to one.
module rpg_lfsr
  import rpg_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  en,
  input  mode_e mode,
  output logic  bit_out
);

  logic [LFSR_W-1:0] s_q;
  logic [4:0]        n_idx;
  logic [4:0]        t_idx;

  // feedback bit from the two active taps
  always_comb begin
    n_idx   = tap_n(mode) - 5'd1;
    t_idx   = tap_t(mode) - 5'd1;
    bit_out = s_q[n_idx] ^ s_q[t_idx];
  end

  // shift state; reload restores the seed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q <= SEED;
    end else if (load) begin
      s_q <= SEED;
    end else if (en) begin
      s_q <= {s_q[LFSR_W-2:0], bit_out} | ~act_mask(mode);
    end
  end

endmodule

// File: rtl/rpg_gen.sv
// Preamble / marker / PRBS pattern generator with reference delay.
// RPG_ERR_INJ_EN adds INJ_ERR / INJ_CNT single-bit error injection.
module rpg_gen
  import rpg_pkg::*;
#(
  parameter int PRE_LEN = 16,
  parameter int MAX_DLY = 64,
  parameter int DLY_W   = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [DLY_W-1:0] DLY_SEL,
  output logic             DUT_DATA,
  output logic             RPG_OUT,
  output logic             RUNNING,
`ifdef RPG_ERR_INJ_EN
  input  logic             INJ_ERR,
  output logic [15:0]      INJ_CNT,
`endif
  output logic [31:0]      BIT_CNT
);

  state_e             state_q;
  state_e             state_d;
  logic [7:0]         pre_q;
  logic [7:0]         pre_d;
  logic               start_q;
  logic               start_rise;
  mode_e              mode_q;
  logic               launch;
  logic               lfsr_ld;
  logic               lfsr_en;
  logic               lfsr_bit;
  logic               dut_nxt;
  logic               dut_ref;
  logic               inj_fire;
  logic [MAX_DLY-2:0] dly_q;
  logic [MAX_DLY-1:0] taps;
  logic [DLY_W-1:0]   sel;

  assign start_rise = START & ~start_q;
  assign RUNNING    = (state_q == RUN);

  rpg_lfsr u_lfsr (
    .CLK     (CLK),
    .RST     (RST),
    .load    (lfsr_ld),
    .en      (lfsr_en),
    .mode    (mode_q),
    .bit_out (lfsr_bit)
  );

  // next state, preamble count and next serial bit
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    launch  = 1'b0;
    lfsr_ld = 1'b0;
    lfsr_en = 1'b0;
    dut_nxt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = PRE;
          pre_d   = 8'(PRE_LEN);
          launch  = 1'b1;
        end
      end
      PRE: begin
        if (!START) begin
          state_d = IDLE;
        end else if (pre_q == 8'd1) begin
          state_d = MARK;
          lfsr_ld = 1'b1;
          dut_nxt = 1'b1;
        end else begin
          pre_d = pre_q - 8'd1;
        end
      end
      MARK, RUN: begin
        if (!START) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
          lfsr_en = 1'b1;
          dut_nxt = lfsr_bit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RPG_ERR_INJ_EN
  logic inj_q;

  assign inj_fire = INJ_ERR & ~inj_q & (state_q == RUN) & START;

  // injection edge detect and saturating count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inj_q   <= 1'b0;
      INJ_CNT <= '0;
    end else begin
      inj_q <= INJ_ERR;
      if (inj_fire && INJ_CNT != 16'hffff) begin
        INJ_CNT <= INJ_CNT + 16'd1;
      end
    end
  end
`else
  assign inj_fire = 1'b0;
`endif

  // FSM, run bookkeeping and registered stimulus
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      start_q  <= 1'b1;
      mode_q   <= MODE_PRBS7;
      BIT_CNT  <= '0;
      DUT_DATA <= 1'b0;
      dut_ref  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      start_q  <= START;
      DUT_DATA <= dut_nxt ^ inj_fire;
      dut_ref  <= dut_nxt;
      if (launch) begin
        mode_q  <= mode_e'(MODE);
        BIT_CNT <= '0;
      end else if (lfsr_en) begin
        BIT_CNT <= BIT_CNT + 32'd1;
      end
    end
  end

  // clamp the delay select to the line depth
  always_comb begin
    taps = {dly_q, dut_ref};
    sel  = DLY_SEL;
    if (int'(DLY_SEL) >= MAX_DLY) begin
      sel = DLY_W'(MAX_DLY - 1);
    end
  end

  // free-running delay line and registered reference tap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dly_q   <= '0;
      RPG_OUT <= 1'b0;
    end else begin
      dly_q   <= taps[MAX_DLY-2:0];
      RPG_OUT <= taps[sel];
    end
  end

endmodule

// File: tb/tb_rpg_gen.sv
// Self-checking bench for rpg_gen against a recurrence-based model.
// Define RPG_ERR_INJ_EN to also exercise error injection.
module tb_rpg_gen;

  localparam int L = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b1;
  logic [1:0]  MODE = 2'd0;
  logic [5:0]  DLY_SEL = 6'd0;
  logic        DUT_DATA;
  logic        RPG_OUT;
  logic        RUNNING;
  logic [31:0] BIT_CNT;
`ifdef RPG_ERR_INJ_EN
  logic        INJ_ERR = 1'b0;
  logic [15:0] INJ_CNT;
`endif

  always #5 CLK = ~CLK;

  rpg_gen #(
    .PRE_LEN (L),
    .MAX_DLY (64),
    .DLY_W   (6)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .MODE     (MODE),
    .DLY_SEL  (DLY_SEL),
    .DUT_DATA (DUT_DATA),
    .RPG_OUT  (RPG_OUT),
    .RUNNING  (RUNNING),
`ifdef RPG_ERR_INJ_EN
    .INJ_ERR  (INJ_ERR),
    .INJ_CNT  (INJ_CNT),
`endif
    .BIT_CNT  (BIT_CNT)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          j = -1;
  int          run_mode = 0;
  int          diffs = 0;
  int          inj_exp = 0;
  logic [31:0] exp_cnt = '0;
  bit          launch_pend = 0;
  bit          abort_pend = 0;
  bit          inv_next = 0;
  bit          hist[$];
  bit          p7[$];
  bit          p15[$];
  bit          obs[$];

  task automatic check(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit ref_bit(int k);
    return (run_mode == 0) ? p7[k] : p15[k];
  endfunction

  task automatic step();
    bit e_clean;
    bit e_dut;
    bit e_rpg;
    int idx;
    @(posedge CLK);
    #1;
    if (launch_pend) begin
      j = 0;
      exp_cnt = '0;
      run_mode = int'(MODE);
      launch_pend = 0;
      obs.delete();
    end else if (abort_pend) begin
      j = -1;
      abort_pend = 0;
    end else if (j >= 0) begin
      j++;
    end
    if (j < L) e_clean = 1'b0;
    else if (j == L) e_clean = 1'b1;
    else e_clean = ref_bit(j - L - 1);
    if (j > L) exp_cnt = 32'(j - L);
    e_dut = e_clean ^ inv_next;
    if (inv_next) inj_exp++;
    inv_next = 0;
    idx = hist.size() - 1 - int'(DLY_SEL);
    e_rpg = (idx >= 0) ? hist[idx] : 1'b0;
    hist.push_back(e_clean);
    if (DUT_DATA !== e_clean) diffs++;
    if (j > L) obs.push_back(DUT_DATA);
    check("dut_data", 32'(DUT_DATA), 32'(e_dut));
    check("running", 32'(RUNNING), 32'(j > L));
    check("bit_cnt", BIT_CNT, exp_cnt);
    check("rpg_out", 32'(RPG_OUT), 32'(e_rpg));
`ifdef RPG_ERR_INJ_EN
    check("inj_cnt", 32'(INJ_CNT), 32'(inj_exp));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch(input logic [1:0] m);
    MODE = m;
    START = 1'b1;
    launch_pend = 1;
  endtask

  task automatic stop();
    START = 1'b0;
    if (j >= 0) abort_pend = 1;
  endtask

`ifdef RPG_ERR_INJ_EN
  task automatic pulse();
    INJ_ERR = 1'b1;
    if (j > L && START && !abort_pend) inv_next = 1;
    step();
    INJ_ERR = 1'b0;
    step();
  endtask
`endif

  initial begin
    bit seed7[7];
    seed7 = '{0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 300; k++) begin
      p7.push_back(((k < 7) ? 1'b1 : p7[k-7]) ^
                   ((k < 6) ? 1'b1 : p7[k-6]));
    end
    for (int k = 0; k < 32767 + 150; k++) begin
      p15.push_back(((k < 15) ? 1'b1 : p15[k-15]) ^
                    ((k < 14) ? 1'b1 : p15[k-14]));
    end

    repeat (3) @(posedge CLK);
    #1;
    check("rst_dut", 32'(DUT_DATA), 32'd0);
    check("rst_rpg", 32'(RPG_OUT), 32'd0);
    check("rst_run", 32'(RUNNING), 32'd0);
    check("rst_cnt", BIT_CNT, 32'd0);
    RST = 1'b0;

    steps(3);
    START = 1'b0;
    steps(2);

    launch(2'd0);
    steps(30);
    MODE = 2'd3;
    steps(20);
    DLY_SEL = 6'd5;
    steps(70);
    DLY_SEL = 6'd63;
    steps(80);
    DLY_SEL = 6'd0;
    steps(L + 255 - 200);
    check("cnt_254", BIT_CNT, 32'd254);
    for (int k = 0; k < 127; k++) begin
      check("per7", 32'(obs[k]), 32'(obs[k+127]));
    end

    stop();
    DLY_SEL = 6'd63;
    steps(70);

    launch(2'd1);
    steps(5);
    stop();
    steps(3);

    launch(2'd1);
    steps(L + 1 + 32767 + 100);
    for (int k = 0; k < 100; k++) begin
      check("per15", 32'(obs[k]), 32'(obs[k+32767]));
    end
    stop();
    steps(3);

    DLY_SEL = 6'd5;
    launch(2'd0);
    steps(L + 1 + 20);
    for (int k = 0; k < 7; k++) begin
      check("seed7", 32'(obs[k]), 32'(seed7[k]));
    end

`ifdef RPG_ERR_INJ_EN
    repeat (3) begin
      pulse();
      steps(4);
    end
    stop();
    steps(2);
    pulse();
    steps(2);
    check("inj_cnt3", 32'(INJ_CNT), 32'd3);
`else
    stop();
    steps(2);
`endif
    check("diffs", 32'(diffs), 32'(inj_exp));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
